// File: rtl/alu_sched_pkg.sv
// Shared constants for alu_sched: opcodes, result width and FSM state encoding.
// ALU_SCHED_DIV_EN adds the DIV state used by the iterative divider.
package alu_sched_pkg;

  localparam int RES_W = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_EXP  = 4'b0101;
  localparam logic [3:0] OP_INC  = 4'b0110;
  localparam logic [3:0] OP_RSV  = 4'b0111;
  localparam logic [3:0] OP_DEC  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_XNOR = 4'b1110;
  localparam logic [3:0] OP_INV  = 4'b1111;

`ifdef ALU_SCHED_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/alu_exec.sv
// Single-cycle opcode decode for alu_sched. DIV/MOD, EXP and 0111 fall into the
// unsupported path here; the top overrides DIV/MOD when the divider is built.
module alu_exec
  import alu_sched_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic [RES_W-1:0] data,
  output logic             err
);

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (op)
      OP_ADD:  data = {4'b0, a + b};
      OP_SUB:  data = {4'b0, a - b};
      OP_MUL:  data = {4'b0, a} * {4'b0, b};
      OP_INC:  data = {4'b0, b + 4'd1};
      OP_DEC:  data = {4'b0, a - 4'd1};
      OP_AND:  data = {4'b0, a & b};
      OP_OR:   data = {4'b0, a | b};
      OP_NAND: data = {4'b0, ~(a & b)};
      OP_NOR:  data = {4'b0, ~(a | b)};
      OP_XOR:  data = {4'b0, a ^ b};
      OP_XNOR: data = {4'b0, ~(a ^ b)};
      OP_INV:  data = {4'b0, ~a};
      default: begin
        data = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester ALU scheduler: arbiter, IDLE/DIV/RESP FSM and optional 4-step
// restoring divider (enabled with ALU_SCHED_DIV_EN).
// Handshake: a request transfers in a cycle where reqN_valid && reqN_ready; the
// response transfers in a cycle where rsp_valid && rsp_ready, outputs held until then.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output state_t           state_dbg
);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic             accept;
  logic [3:0]       sel_op, sel_a, sel_b;
  logic [RES_W-1:0] exec_data;
  logic             exec_err;

  always_comb begin
    if (req0_valid && req1_valid)
      grant_id = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
    else
      grant_id = ~req0_valid;
    accept     = (state == ST_IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    sel_op     = grant_id ? req1_op : req0_op;
    sel_a      = grant_id ? req1_a  : req0_a;
    sel_b      = grant_id ? req1_b  : req0_b;
  end

  alu_exec u_exec (
    .op   (sel_op),
    .a    (sel_a),
    .b    (sel_b),
    .data (exec_data),
    .err  (exec_err)
  );

`ifdef ALU_SCHED_DIV_EN
  logic       div_start, div_done;
  logic [3:0] div_rem, div_quo, div_b;
  logic [1:0] div_cnt;
  logic       div_mod, div_zero;
  logic [3:0] st_rem, st_quo, st_d, rem_n, quo_n;
  logic [4:0] shifted;

  // Iteration 1 runs on the acceptance edge, the remaining three in DIV.
  // With a zero divisor every step subtracts nothing, so the quotient ends at
  // all ones and the remainder at a, which is exactly the required result.
  always_comb begin
    div_start = accept && (sel_op == OP_DIV || sel_op == OP_MOD);
    div_done  = (state == ST_DIV) && (div_cnt == 2'd3);
    st_rem    = (state == ST_DIV) ? div_rem : 4'd0;
    st_quo    = (state == ST_DIV) ? div_quo : sel_a;
    st_d      = (state == ST_DIV) ? div_b   : sel_b;
    shifted   = {st_rem, st_quo[3]};
    if (shifted >= {1'b0, st_d}) begin
      rem_n = shifted[3:0] - st_d;
      quo_n = {st_quo[2:0], 1'b1};
    end else begin
      rem_n = shifted[3:0];
      quo_n = {st_quo[2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_rem  <= '0;
      div_quo  <= '0;
      div_b    <= '0;
      div_cnt  <= '0;
      div_mod  <= 1'b0;
      div_zero <= 1'b0;
    end else if (div_start) begin
      div_rem  <= rem_n;
      div_quo  <= quo_n;
      div_b    <= sel_b;
      div_cnt  <= 2'd1;
      div_mod  <= (sel_op == OP_MOD);
      div_zero <= (sel_b == 4'd0);
    end else if (state == ST_DIV) begin
      div_rem <= rem_n;
      div_quo <= quo_n;
      div_cnt <= div_cnt + 2'd1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_SCHED_DIV_EN
          state_nxt = div_start ? ST_DIV : ST_RESP;
`else
          state_nxt = ST_RESP;
`endif
        end
      end
`ifdef ALU_SCHED_DIV_EN
      ST_DIV:  if (div_done) state_nxt = ST_RESP;
`endif
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant_id;
        rsp_id     <= grant_id;
        rsp_data   <= exec_data;
        rsp_err    <= exec_err;
      end
`ifdef ALU_SCHED_DIV_EN
      if (div_done) begin
        rsp_data <= {4'b0, div_mod ? rem_n : quo_n};
        rsp_err  <= div_zero;
      end
`endif
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter PRIO_FIXED, default 0; 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  request pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  4  opcode.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4  operands.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_id  output  1  requester index of the result.
REQ-011 SHALL have port rsp_data  output  8  result; 4-bit results zero-extended.
REQ-012 SHALL have port rsp_err  output  1  unsupported op or divide-by-zero.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL use opcodes ADD 0000, SUB 0001, MUL 0010, DIV 0011, MOD 0100, EXP 0101, INC 0110, DEC 1000, AND 1001, OR 1010, NAND 1011, NOR 1100, XOR 1101, XNOR 1110, INV 1111.
REQ-015 SHALL compute: ADD/SUB mod 16; MUL full 8-bit a*b; INC = b+1 mod 16; DEC = a-1 mod 16; logic ops bitwise on 4 bits; INV = ~a.
REQ-016 SHALL treat EXP and 0111 as unsupported: rsp_data 0x00, rsp_err 1.
REQ-017 SHALL implement FSM states IDLE, DIV, RESP.
REQ-018 SHALL assert reqN_ready combinationally only in IDLE, only for the granted requester, and only when reqN_valid is high; at most one ready per cycle.
REQ-019 SHALL, when PRIO_FIXED=0 and both requests are valid, grant the requester not granted last; the last-grant pointer updates only on acceptance.
REQ-020 SHALL, on acceptance of a non-DIV/MOD op, register the result and go IDLE->RESP; rsp_valid is high 1 cycle after acceptance.
REQ-021 SHALL, on acceptance of DIV/MOD, capture operands, go to DIV, and perform a restoring shift-subtract of 4 iterations (1 per cycle), then go to RESP; rsp_valid is high 4 cycles after acceptance.
REQ-022 SHALL return quotient for DIV and remainder for MOD, zero-extended.
REQ-023 SHALL, on divide-by-zero, return 0x0F (DIV) or a (MOD) with rsp_err 1, using the same 4-cycle latency.
REQ-024 SHALL hold rsp_valid, rsp_id, rsp_data and rsp_err stable in RESP until rsp_ready is sampled high, then go to IDLE; no new request is accepted in that same cycle.
REQ-025 SHALL assume requesters hold op and operands stable while valid is high and ready is low; inputs are sampled only on the acceptance cycle.

Reset
REQ-026 SHALL, on rst high, immediately force state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0x00, rsp_err 0, busy 0, and last-grant pointer 1 (requester 0 wins first).
REQ-027 SHALL abandon any in-flight DIV or pending RESP on reset mid-operation; no response is produced for it.

Configuration
REQ-028 SHALL, with ALU_SCHED_DIV_EN defined, implement the iterative divider and DIV state as in REQ-021..023.
REQ-029 SHALL, without ALU_SCHED_DIV_EN, treat DIV/MOD as unsupported per REQ-016 with 1-cycle latency; the DIV state and divider logic are absent.

Structure
REQ-030 SHALL place opcode constants, FSM state encoding and result width (8) in the shared package alu_sched_pkg.
REQ-031 SHALL place the single-cycle op decode (REQ-015/016) in sub-module alu_exec; the divider, arbiter and FSM stay in alu_sched.

Verification
REQ-032 SHALL cover: req0 ADD a=9 b=8 -> rsp_data 0x01, rsp_err 0, rsp_id 0, one cycle after acceptance.
REQ-033 SHALL cover: req1 MUL a=15 b=15 -> rsp_data 0xE1; DEC a=0 -> 0x0F.
REQ-034 SHALL cover: with ALU_SCHED_DIV_EN, DIV a=13 b=4 -> 0x03 after 4 cycles; MOD a=13 b=4 -> 0x01; DIV b=0 -> 0x0F with err 1.
REQ-035 SHALL cover: both requesters held valid for 4 ops -> grants 0,1,0,1 with PRIO_FIXED=0, and 0,0,0,0 with PRIO_FIXED=1.
REQ-036 SHALL cover: rsp_ready held low 5 cycles -> outputs stable and both ready signals low; release -> IDLE, next grant the cycle after.
REQ-037 SHALL cover: rst pulsed during DIV iteration 2 -> all outputs at reset values immediately; no response emitted afterward.
